// File: rtl/rgb2hsv_pkg.sv
// Purpose: shared widths, hue-sector constant and data types for the RGB-to-HSV front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: IN_W/D_W/H_W widths, HUE_SECTOR, pix_t (unsigned channel), dval_t and hval_t (signed results).
package rgb2hsv_pkg;

  localparam int IN_W       = 8;   // unsigned colour channel width
  localparam int D_W        = 10;  // signed V/min/chroma/difference width
  localparam int H_W        = 16;  // signed scaled hue-sector width
  localparam int HUE_SECTOR = 60;  // hue units per sector

  typedef logic        [IN_W-1:0] pix_t;
  typedef logic signed [D_W-1:0]  dval_t;
  typedef logic signed [H_W-1:0]  hval_t;

endpackage

// File: rtl/hue_scale_div.sv
// Purpose: scale a signed channel difference to one hue sector, (HUE_SECTOR*diff)/chroma.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: diff, chroma (signed D_W) in; q (signed H_W) out, 0 when chroma is 0.
module hue_scale_div
  import rgb2hsv_pkg::*;
#(
  parameter int D_W = rgb2hsv_pkg::D_W,
  parameter int H_W = rgb2hsv_pkg::H_W
) (
  input  logic signed [D_W-1:0] diff,
  input  logic signed [D_W-1:0] chroma,
  output logic signed [H_W-1:0] q
);

  localparam logic signed [H_W-1:0] SECTOR = H_W'(HUE_SECTOR);

  logic signed [H_W-1:0] diff_x;
  logic signed [H_W-1:0] chroma_x;
  logic signed [H_W-1:0] prod;

  // Sign-extend both operands so multiply and divide stay in the signed H_W domain.
  assign diff_x   = {{(H_W-D_W){diff[D_W-1]}}, diff};
  assign chroma_x = {{(H_W-D_W){chroma[D_W-1]}}, chroma};
  assign prod     = diff_x * SECTOR;

  // Signed division truncates toward zero, so the result stays within -60..60.
  // A grey pixel has zero chroma and every difference zero; report 0 instead of dividing.
  always_comb begin
    q = '0;
    if (chroma_x != '0) begin
      q = prod / chroma_x;
    end
  end

endmodule

// File: rtl/rgb2hsv_front.sv
// Purpose: RGB-to-HSV front end: V/min, chroma plus channel differences, differences scaled to a hue sector.
// Latency: 3 cycles in_valid -> out_valid, one pixel per clock.
// Backpressure: none; the pipeline never stalls, bubbles (in_valid=0) flow through as out_valid=0.
// Ports: clk, rst_n (sync, active-low); in_valid, r, g, b in;
//        out_valid, v, min, s, gb, br, rg (signed D_W), gb_s3, br_s3, rg_s3 (signed H_W) out.
module rgb2hsv_front
  import rgb2hsv_pkg::*;
#(
  parameter int IN_W = rgb2hsv_pkg::IN_W,
  parameter int D_W  = rgb2hsv_pkg::D_W,
  parameter int H_W  = rgb2hsv_pkg::H_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       r,
  input  logic [IN_W-1:0]       g,
  input  logic [IN_W-1:0]       b,
  output logic                  out_valid,
  output logic signed [D_W-1:0] v,
  output logic signed [D_W-1:0] min,
  output logic signed [D_W-1:0] s,
  output logic signed [D_W-1:0] gb,
  output logic signed [D_W-1:0] br,
  output logic signed [D_W-1:0] rg,
  output logic signed [H_W-1:0] gb_s3,
  output logic signed [H_W-1:0] br_s3,
  output logic signed [H_W-1:0] rg_s3
);

  // ---------------------------------------------------------------------------
  // Stage 1: zero-extend the channels, find max (V) and min.
  // ---------------------------------------------------------------------------
  logic signed [D_W-1:0] r_x, g_x, b_x;
  logic signed [D_W-1:0] max_c, min_c;

  // Zero-extension keeps every channel non-negative in the signed domain.
  assign r_x = {{(D_W-IN_W){1'b0}}, r};
  assign g_x = {{(D_W-IN_W){1'b0}}, g};
  assign b_x = {{(D_W-IN_W){1'b0}}, b};

  always_comb begin
    max_c = r_x;
    if (g_x > max_c) max_c = g_x;
    if (b_x > max_c) max_c = b_x;
    min_c = r_x;
    if (g_x < min_c) min_c = g_x;
    if (b_x < min_c) min_c = b_x;
  end

  logic                  s1_vld;
  logic signed [D_W-1:0] s1_v, s1_min, s1_r, s1_g, s1_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_v   <= '0;
      s1_min <= '0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= in_valid;
      s1_v   <= max_c;
      s1_min <= min_c;
      s1_r   <= r_x;
      s1_g   <= g_x;
      s1_b   <= b_x;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: chroma and pairwise differences; V/min ride along.
  // ---------------------------------------------------------------------------
  logic                  s2_vld;
  logic signed [D_W-1:0] s2_v, s2_min, s2_s, s2_gb, s2_br, s2_rg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_v   <= '0;
      s2_min <= '0;
      s2_s   <= '0;
      s2_gb  <= '0;
      s2_br  <= '0;
      s2_rg  <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_v   <= s1_v;
      s2_min <= s1_min;
      s2_s   <= s1_v - s1_min;
      s2_gb  <= s1_g - s1_b;
      s2_br  <= s1_b - s1_r;
      s2_rg  <= s1_r - s1_g;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: scale each difference to a hue sector; everything else is delayed
  // one more cycle so all outputs belong to the same pixel.
  // ---------------------------------------------------------------------------
  logic signed [H_W-1:0] q_gb, q_br, q_rg;

  hue_scale_div #(.D_W(D_W), .H_W(H_W)) u_div_gb (.diff(s2_gb), .chroma(s2_s), .q(q_gb));
  hue_scale_div #(.D_W(D_W), .H_W(H_W)) u_div_br (.diff(s2_br), .chroma(s2_s), .q(q_br));
  hue_scale_div #(.D_W(D_W), .H_W(H_W)) u_div_rg (.diff(s2_rg), .chroma(s2_s), .q(q_rg));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      v         <= '0;
      min       <= '0;
      s         <= '0;
      gb        <= '0;
      br        <= '0;
      rg        <= '0;
      gb_s3     <= '0;
      br_s3     <= '0;
      rg_s3     <= '0;
    end else begin
      out_valid <= s2_vld;
      v         <= s2_v;
      min       <= s2_min;
      s         <= s2_s;
      gb        <= s2_gb;
      br        <= s2_br;
      rg        <= s2_rg;
      gb_s3     <= q_gb;
      br_s3     <= q_br;
      rg_s3     <= q_rg;
    end
  end

endmodule

// File: tb/tb_rgb2hsv_front.sv
// Purpose: self-checking bench for rgb2hsv_front against a plain-arithmetic reference model.
// Latency: expects every pixel 3 clocks after it is sampled.
// Backpressure: none exercised; the DUT has no stall.
module tb_rgb2hsv_front;
  import rgb2hsv_pkg::*;

  typedef struct packed {
    logic  ov;
    dval_t v, mn, s, gb, br, rg;
    hval_t gbs, brs, rgs;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  pix_t  r, g, b;
  logic  out_valid;
  dval_t v, min, s, gb, br, rg;
  hval_t gb_s3, br_s3, rg_s3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb2hsv_front dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .r(r), .g(g), .b(b),
    .out_valid(out_valid), .v(v), .min(min), .s(s),
    .gb(gb), .br(br), .rg(rg),
    .gb_s3(gb_s3), .br_s3(br_s3), .rg_s3(rg_s3)
  );

  function automatic obs_t obs();
    obs_t o;
    o.ov = out_valid; o.v = v; o.mn = min; o.s = s;
    o.gb = gb; o.br = br; o.rg = rg;
    o.gbs = gb_s3; o.brs = br_s3; o.rgs = rg_s3;
    return o;
  endfunction

  // Reference: integer arithmetic straight from the channel values.
  function automatic int sector(input int d, input int c);
    if (c == 0) return 0;
    return (HUE_SECTOR * d) / c;  // int division truncates toward zero
  endfunction

  function automatic obs_t model(input logic vld, input int rr, input int gg, input int bb);
    obs_t e;
    int mx, mn, c;
    mx = (rr > gg) ? rr : gg;
    mx = (bb > mx) ? bb : mx;
    mn = (rr < gg) ? rr : gg;
    mn = (bb < mn) ? bb : mn;
    c  = mx - mn;
    e.ov  = vld;
    e.v   = dval_t'(mx);
    e.mn  = dval_t'(mn);
    e.s   = dval_t'(c);
    e.gb  = dval_t'(gg - bb);
    e.br  = dval_t'(bb - rr);
    e.rg  = dval_t'(rr - gg);
    e.gbs = hval_t'(sector(gg - bb, c));
    e.brs = hval_t'(sector(bb - rr, c));
    e.rgs = hval_t'(sector(rr - gg, c));
    return e;
  endfunction

  function automatic obs_t mk(input int vv, input int mn, input int ss, input int d0, input int d1,
                              input int d2, input int q0, input int q1, input int q2);
    obs_t e;
    e.ov = 1'b1; e.v = dval_t'(vv); e.mn = dval_t'(mn); e.s = dval_t'(ss);
    e.gb = dval_t'(d0); e.br = dval_t'(d1); e.rg = dval_t'(d2);
    e.gbs = hval_t'(q0); e.brs = hval_t'(q1); e.rgs = hval_t'(q2);
    return e;
  endfunction

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0; in_valid = 1'b1; r = 8'd10; g = 8'd20; b = 8'd30;
    repeat (2) @(posedge clk);
    #1;
    o = obs();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h required 0", o);
    end
    rst_n = 1'b1; in_valid = 1'b0; r = '0; g = '0; b = '0;
  endtask

  // Hand-computed vectors, one pixel at a time, checking exact latency.
  task automatic test_directed();
    pix_t  tr[5];
    pix_t  tg[5];
    pix_t  tbl[5];
    obs_t  te[5];
    obs_t  o;
    tr[0] = 8'd1;   tg[0] = 8'd0;   tbl[0] = 8'd0;   te[0] = mk(1, 0, 1, 0, -1, 1, 0, -60, 60);
    tr[1] = 8'd80;  tg[1] = 8'd128; tbl[1] = 8'd54;  te[1] = mk(128, 54, 74, 74, -26, -48, 60, -21, -38);
    tr[2] = 8'd200; tg[2] = 8'd200; tbl[2] = 8'd200; te[2] = mk(200, 200, 0, 0, 0, 0, 0, 0, 0);
    tr[3] = 8'd255; tg[3] = 8'd0;   tbl[3] = 8'd0;   te[3] = mk(255, 0, 255, 0, -255, 255, 0, -60, 60);
    tr[4] = 8'd0;   tg[4] = 8'd0;   tbl[4] = 8'd255; te[4] = mk(255, 0, 255, -255, 255, 0, -60, 60, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; r = tr[i]; g = tg[i]; b = tbl[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid got %b required 0", i, out_valid);
      end
      @(posedge clk); #1;
      o = obs();
      n_cmp++;
      if (o !== te[i]) begin
        n_err++;
        $display("FAIL directed[%0d]: got %h required %h", i, o, te[i]);
      end
    end
  endtask

  // Back-to-back valid pixels with a bubble every third slot.
  task automatic test_back_to_back();
    obs_t q[$];
    obs_t e, o;
    for (int i = 0; i < 33; i++) begin
      @(posedge clk); #1;
      if (q.size() == 3) begin
        e = q.pop_front();
        o = obs();
        n_cmp++;
        if (e.ov ? (o !== e) : (o.ov !== 1'b0)) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: got %h required %h", i, o, e);
        end
      end
      if (i < 30) begin
        in_valid = ((i % 3) != 2);
        r = pix_t'($urandom_range(255));
        g = pix_t'($urandom_range(255));
        b = pix_t'($urandom_range(255));
      end else begin
        in_valid = 1'b0;
      end
      q.push_back(model(in_valid, int'(r), int'(g), int'(b)));
    end
    in_valid = 1'b0;
  endtask

  // Random valid pattern with grey and extreme channel values mixed in.
  task automatic test_random();
    obs_t q[$];
    obs_t e, o;
    int   mode;
    for (int i = 0; i < 203; i++) begin
      @(posedge clk); #1;
      if (q.size() == 3) begin
        e = q.pop_front();
        o = obs();
        n_cmp++;
        if (e.ov ? (o !== e) : (o.ov !== 1'b0)) begin
          n_err++;
          $display("FAIL random[%0d]: got %h required %h", i, o, e);
        end
      end
      if (i < 200) begin
        in_valid = ($urandom_range(3) != 0);
        mode = int'($urandom_range(7));
        r = pix_t'($urandom_range(255));
        g = pix_t'($urandom_range(255));
        b = pix_t'($urandom_range(255));
        if (mode == 0) begin
          g = r; b = r;
        end else if (mode == 1) begin
          r = ($urandom_range(1) != 0) ? 8'd255 : 8'd0;
          g = ($urandom_range(1) != 0) ? 8'd255 : 8'd0;
          b = ($urandom_range(1) != 0) ? 8'd255 : 8'd0;
        end
      end else begin
        in_valid = 1'b0;
      end
      q.push_back(model(in_valid, int'(r), int'(g), int'(b)));
    end
    in_valid = 1'b0;
  endtask

  // Reset with two pixels in flight and a third presented on the reset edge.
  task automatic test_reset_midstream();
    obs_t o, e;
    in_valid = 1'b1; r = 8'd90; g = 8'd10; b = 8'd40;
    @(posedge clk); #1;
    r = 8'd5; g = 8'd250; b = 8'd100;
    @(posedge clk); #1;
    r = 8'd255; g = 8'd1; b = 8'd2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    o = obs();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_flush: got %h required 0", o);
    end
    rst_n = 1'b1; in_valid = 1'b0; r = '0; g = '0; b = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_ghost[%0d]: out_valid got %b required 0", i, out_valid);
      end
    end
    in_valid = 1'b1; r = 8'd30; g = 8'd170; b = 8'd99;
    e = model(1'b1, 30, 170, 99);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_recover_early: out_valid got %b required 0", out_valid);
    end
    @(posedge clk); #1;
    o = obs();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_recover: got %h required %h", o, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; r = '0; g = '0; b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb2hsv_front.md
# rgb2hsv_front

Front end of the RGB-to-HSV pixel pipeline: covers the s1, s2 and s3 stages.
- s1: maximum (V) and minimum of the three colour channels.
- s2: chroma and the three pairwise channel differences.
- s3: each difference scaled to a 60-unit hue sector (60·diff/chroma).

The block is fully pipelined and accepts one pixel per clock. Its outputs feed the downstream hue/saturation stages (s4–s8).

## Interface
Parameters:
- IN_W, 8, unsigned colour channel width
- D_W, 10, signed width of V/min/chroma/difference results
- H_W, 16, signed width of scaled hue-sector terms

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  pixel on r/g/b is valid this cycle
- r, g, b  input  IN_W each  unsigned colour channels
- out_valid  output  1  outputs below hold a valid pixel
- v  output  D_W  signed, max(r,g,b)
- min  output  D_W  signed, min(r,g,b)
- s  output  D_W  signed chroma, v − min (always ≥ 0)
- gb, br, rg  output  D_W each  signed g−b, b−r, r−g
- gb_s3, br_s3, rg_s3  output  H_W each  signed (60·diff)/s

## Operation
- Inputs are zero-extended to D_W before any arithmetic.
- Stage 1 registers:
  - v = max(r,g,b), min = min(r,g,b);
  - zero-extended r, g, b, carried for stage 2;
  - in_valid.
- Stage 2 registers:
  - s = v − min;
  - gb = g − b, br = b − r, rg = r − g;
  - v and min, delayed for alignment.
- Stage 3 registers:
  - X_s3 = (60·X)/s for X ∈ {gb, br, rg};
  - all stage-2 values, delayed for alignment.
- s3 arithmetic:
  - signed multiply by 60 into H_W (|60·255| = 15300 fits);
  - signed division, quotient truncated toward zero;
  - result range −60..60.
- Division by zero: when s = 0 (grey pixel, r = g = b), all three X_s3 are 0. No exception is raised.
- All outputs are registered and mutually aligned: every value belongs to the same pixel as out_valid.
- When in_valid = 0, the data registers still advance (don't-care contents), and out_valid reports the bubble three cycles later.

## Timing
- Latency is exactly 3 clocks, in_valid → out_valid. Throughput is 1 pixel/clock; there is no back-pressure or stall.
- Reset (rst_n low at a rising edge): all pipeline registers are cleared.
  - Every output, including out_valid, reads 0 starting the cycle after the reset edge.
  - Pixels in flight during reset are discarded.
  - The first valid output appears 3 clocks after the first in_valid sampled with rst_n high.
- Simultaneous in_valid and reset: reset wins, and the pixel is dropped.

## Structure
- Shared package rgb2hsv_pkg holds:
  - the IN_W, D_W, H_W constants;
  - the sector constant HUE_SECTOR = 60;
  - typedefs pix_t (IN_W unsigned), dval_t (D_W signed), hval_t (H_W signed).
- One sub-module, hue_scale_div: combinational (60·diff)/chroma with the zero-divisor rule. It is instantiated three times in stage 3.
- Stages 1–2 are inline in the top.

## Test plan
- Basic pixel: r=1, g=0, b=0 → after 3 clk: v=1, min=0, s=1, gb=0, br=−1, rg=1, gb_s3=0, br_s3=−60, rg_s3=60, out_valid=1.
- Mixed pixel: r=80, g=128, b=54 → v=128, min=54, s=74, gb=74, br=−26, rg=−48, gb_s3=60, br_s3=−21, rg_s3=−38 (truncation toward zero).
- Grey pixel, zero divisor: r=g=b=200 → v=min=200, s=0, all differences 0, all X_s3=0.
- Extremes: r=255, g=0, b=0 → v=255, s=255, gb=0, br=−255, rg=255, br_s3=−60, rg_s3=60.
  - Also r=0, g=0, b=255 → gb=−255, gb_s3=−60, br_s3=60, rg_s3=0.
- Streaming and alignment: back-to-back pixels with an in_valid=0 bubble between them. Each output set must match its own pixel exactly 3 clocks later, and out_valid must be 0 in the bubble slot.
- Reset mid-stream: assert rst_n=0 with two pixels in flight.
  - All outputs and out_valid are 0 on the next cycle; no in-flight pixel emerges.
  - After release, the next pixel appears after 3 clocks.
